// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank.
//   - Register byte offsets for the global block and per-channel windows.
//   - Counter mode encoding.
//   - INFO word builder, so the read mux and any software model agree on layout.
package perf_pkg;

  // Global registers
  localparam int GCTRL_OFS = 'h00;
  localparam int INFO_OFS  = 'h04;

  // Channel windows: channel n lives at CH_BASE + CH_STRIDE*n
  localparam int CH_BASE   = 'h10;
  localparam int CH_STRIDE = 'h10;

  // Offsets inside a channel window
  localparam int CTRL_OFS  = 'h0;
  localparam int LO_OFS    = 'h4;
  localparam int HI_OFS    = 'h8;
  localparam int STAT_OFS  = 'hC;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_CYCLE = 2'd1,
    MODE_HOLD  = 2'd2,
    MODE_EVENT = 2'd3
  } mode_e;

  // INFO layout: [3:0] channel count, [14:8] counter width.
  function automatic logic [31:0] info_word(input int num_cntrs, input int cnt_width);
    return {17'h0, cnt_width[6:0], 4'h0, num_cntrs[3:0]};
  endfunction

endpackage

// File: rtl/perf_cntr_slice.sv
// One counter channel: counter, hi-word read shadow, mode, overflow-irq enable
// and sticky overflow flag.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_all          global clear pulse (highest priority, never sets ovf)
//   global_en          counting enable shared by all channels
//   evt                event level for EVENT mode
//   ctrl_we/lo_we/hi_we/stat_we  decoded write strobes for this channel
//   lo_re              LO read strobe; latches the hi-word shadow
//   wdata              bus write data
//   cnt_lo             cnt[31:0] for the read mux
//   shadow             hi word captured by the last LO read
//   mode, ovf_ie, ovf  control/status for the read mux and irq
module perf_cntr_slice
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_all,
  input  logic                  global_en,
  input  logic                  evt,
  input  logic                  ctrl_we,
  input  logic                  lo_we,
  input  logic                  hi_we,
  input  logic                  stat_we,
  input  logic                  lo_re,
  input  logic [31:0]           wdata,
  output logic [31:0]           cnt_lo,
  output logic [CNT_WIDTH-33:0] shadow,
  output logic [1:0]            mode,
  output logic                  ovf_ie,
  output logic                  ovf
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]      shadow_q;
  mode_e                mode_q;
  logic                 ovf_ie_q, ovf_q;
  logic                 inc, wrap;

  // Priority: clear_all > CLEAR mode > bus write > increment.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    wrap  = 1'b0;
    inc   = global_en &&
            ((mode_q == MODE_CYCLE) || ((mode_q == MODE_EVENT) && evt));
    if (clear_all || (mode_q == MODE_CLEAR)) begin
      cnt_d = '0;
    end else if (lo_we) begin
      cnt_d[31:0] = wdata;
    end else if (hi_we) begin
      cnt_d[CNT_WIDTH-1:32] = wdata[HI_W-1:0];
    end else if (inc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      wrap  = &cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      mode_q   <= MODE_CLEAR;
      ovf_ie_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so the shadow below captures the
      // pre-edge counter even when a write lands on the same edge.
      cnt_q <= cnt_d;
      if (lo_re) begin
        shadow_q <= cnt_q[CNT_WIDTH-1:32];
      end
      if (ctrl_we) begin
        mode_q   <= mode_e'(wdata[1:0]);
        ovf_ie_q <= wdata[2];
      end
      // A wrap on the same edge as a W1C wins: the event must not be lost.
      ovf_q <= (ovf_q && !(stat_we && wdata[0])) || wrap;
    end
  end

  assign cnt_lo = cnt_q[31:0];
  assign shadow = shadow_q;
  assign mode   = mode_q;
  assign ovf_ie = ovf_ie_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/perf_cntr_bank.sv
// Multi-channel performance-counter bank on the dbus window.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   addr_i         byte address (bits [1:0] ignored)
//   wdata_i        write data
//   we_i, re_i     write / read strobes
//   event_i        per-channel event levels
//   rdata_o        registered read data (updates only on re_i)
//   irq_o          registered OR of ovf & ovf_ie over all channels
module perf_cntr_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNTRS  = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [NUM_CNTRS-1:0]  event_i,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  localparam int          HI_W     = CNT_WIDTH - 32;
  localparam int          BLK_W    = ADDR_WIDTH - 4;
  localparam logic [31:0] INFO_VAL = info_word(NUM_CNTRS, CNT_WIDTH);

  logic [ADDR_WIDTH-1:0] addr_w;
  logic [3:0]            reg_ofs;
  logic                  gctrl_hit, info_hit, clear_all, global_en;
  logic [NUM_CNTRS-1:0]  ch_sel, ovf, ovf_ie;
  logic [31:0]           cnt_lo [NUM_CNTRS];
  logic [HI_W-1:0]       shadow [NUM_CNTRS];
  logic [1:0]            mode   [NUM_CNTRS];
  logic [31:0]           rd_val;
  logic                  unused_addr;

  // Byte-lane bits carry no meaning for word registers.
  assign unused_addr = ^addr_i[1:0];

  assign addr_w    = {addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign reg_ofs   = {addr_i[3:2], 2'b00};
  assign gctrl_hit = (addr_w == ADDR_WIDTH'(GCTRL_OFS));
  assign info_hit  = (addr_w == ADDR_WIDTH'(INFO_OFS));
  assign clear_all = we_i && gctrl_hit && wdata_i[1];

  for (genvar n = 0; n < NUM_CNTRS; n++) begin : g_ch
    // Channels outside NUM_CNTRS never match, so their window reads 0.
    assign ch_sel[n] = (addr_i[ADDR_WIDTH-1:4] == BLK_W'((CH_BASE + CH_STRIDE * n) >> 4));

    perf_cntr_slice #(.CNT_WIDTH(CNT_WIDTH)) u_slice (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_all (clear_all),
      .global_en (global_en),
      .evt       (event_i[n]),
      .ctrl_we   (we_i && ch_sel[n] && (reg_ofs == 4'(CTRL_OFS))),
      .lo_we     (we_i && ch_sel[n] && (reg_ofs == 4'(LO_OFS))),
      .hi_we     (we_i && ch_sel[n] && (reg_ofs == 4'(HI_OFS))),
      .stat_we   (we_i && ch_sel[n] && (reg_ofs == 4'(STAT_OFS))),
      .lo_re     (re_i && ch_sel[n] && (reg_ofs == 4'(LO_OFS))),
      .wdata     (wdata_i),
      .cnt_lo    (cnt_lo[n]),
      .shadow    (shadow[n]),
      .mode      (mode[n]),
      .ovf_ie    (ovf_ie[n]),
      .ovf       (ovf[n])
    );
  end

  always_comb begin
    rd_val = 32'h0;
    if (gctrl_hit) begin
      rd_val = {31'h0, global_en};
    end else if (info_hit) begin
      rd_val = INFO_VAL;
    end
    for (int n = 0; n < NUM_CNTRS; n++) begin
      if (ch_sel[n]) begin
        case (reg_ofs)
          4'(CTRL_OFS): rd_val = {29'h0, ovf_ie[n], mode[n]};
          4'(LO_OFS):   rd_val = cnt_lo[n];
          4'(HI_OFS):   rd_val = 32'(shadow[n]);
          4'(STAT_OFS): rd_val = {31'h0, ovf[n]};
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      global_en <= 1'b0;
      rdata_o   <= 32'h0;
      irq_o     <= 1'b0;
    end else begin
      if (we_i && gctrl_hit) begin
        global_en <= wdata_i[0];
      end
      if (re_i) begin
        rdata_o <= rd_val;
      end
      irq_o <= |(ovf & ovf_ie);
    end
  end

endmodule

// File: tb/tb_perf_cntr_bank.sv
// Self-checking bench for perf_cntr_bank: directed scenarios with literal
// expectations, then randomized bus traffic, all compared every cycle against
// a register-level behavioural model.
module tb_perf_cntr_bank;

  localparam int NUM_CNTRS  = 4;
  localparam int CNT_WIDTH  = 64;
  localparam int ADDR_WIDTH = 8;
  localparam logic [64:0]     CMASK65 = (65'd1 << CNT_WIDTH) - 65'd1;
  localparam longint unsigned CMASK   = CMASK65[63:0];

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  we_i, re_i;
  logic [NUM_CNTRS-1:0]  event_i;
  logic [31:0]           rdata_o;
  logic                  irq_o;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  perf_cntr_bank #(
    .NUM_CNTRS (NUM_CNTRS),
    .CNT_WIDTH (CNT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .we_i   (we_i),
    .re_i   (re_i),
    .event_i(event_i),
    .rdata_o(rdata_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (register view) ----------------
  longint unsigned m_cnt    [NUM_CNTRS];
  longint unsigned m_shadow [NUM_CNTRS];
  logic [1:0]      m_mode   [NUM_CNTRS];
  bit              m_ie     [NUM_CNTRS];
  bit              m_ovf    [NUM_CNTRS];
  bit              m_gen;
  logic [31:0]     m_rdata;
  bit              m_irq;

  function automatic int chan_of(input logic [7:0] a);
    int blk;
    blk = int'(a[7:4]);
    if (blk >= 1 && blk <= NUM_CNTRS) return blk - 1;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int ch;
    int word;
    ch   = chan_of(a);
    word = int'(a) & 'hFC;
    if (word == 0) return {31'h0, m_gen};
    if (word == 4) return 32'((CNT_WIDTH << 8) | NUM_CNTRS);
    if (ch < 0) return 32'h0;
    case (word & 'hC)
      0:       return 32'(m_mode[ch]) | (32'(m_ie[ch]) << 2);
      4:       return m_cnt[ch][31:0];
      8:       return m_shadow[ch][31:0];
      default: return {31'h0, m_ovf[ch]};
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_CNTRS; n++) begin
        m_cnt[n] = 0; m_shadow[n] = 0; m_mode[n] = 2'd0; m_ie[n] = 0; m_ovf[n] = 0;
      end
      m_gen = 0; m_rdata = 32'h0; m_irq = 0;
    end else begin
      int ch;
      int rg;
      bit clr;
      ch  = chan_of(addr_i);
      rg  = int'(addr_i[3:2]);
      clr = we_i && (addr_i[7:2] == 6'd0) && wdata_i[1];
      // irq reflects the flags as they stood before this edge
      m_irq = 0;
      for (int n = 0; n < NUM_CNTRS; n++) if (m_ovf[n] && m_ie[n]) m_irq = 1;
      // reads see pre-edge state, including pre-write counters
      if (re_i) begin
        m_rdata = model_read(addr_i);
        if (ch >= 0 && rg == 1) m_shadow[ch] = m_cnt[ch] >> 32;
      end
      for (int n = 0; n < NUM_CNTRS; n++) begin
        bit hit_w;
        bit inc;
        bit wrap;
        hit_w = we_i && (ch == n);
        inc   = m_gen && (m_mode[n] == 2'd1 || (m_mode[n] == 2'd3 && event_i[n]));
        wrap  = 0;
        if (clr || m_mode[n] == 2'd0) m_cnt[n] = 0;
        else if (hit_w && rg == 1) m_cnt[n] = (m_cnt[n] & ~64'hFFFF_FFFF) | 64'(wdata_i);
        else if (hit_w && rg == 2) m_cnt[n] = ((64'(wdata_i) << 32) | (m_cnt[n] & 64'hFFFF_FFFF)) & CMASK;
        else if (inc) begin
          if (m_cnt[n] == CMASK) begin m_cnt[n] = 0; wrap = 1; end
          else m_cnt[n] = m_cnt[n] + 1;
        end
        if (hit_w && rg == 3 && wdata_i[0]) m_ovf[n] = 0;
        if (wrap) m_ovf[n] = 1;
        if (hit_w && rg == 0) begin m_mode[n] = wdata_i[1:0]; m_ie[n] = wdata_i[2]; end
      end
      if (we_i && addr_i[7:2] == 6'd0) m_gen = wdata_i[0];
    end
  end

  // Compare process: outputs are registered, so check on the falling edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("rdata_o vs model", rdata_o, m_rdata);
      check("irq_o vs model", {31'h0, irq_o}, {31'h0, m_irq});
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  function automatic logic [7:0] ch_addr(input int n, input int ofs);
    return 8'('h10 + 'h10 * n + ofs);
  endfunction

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input string name, input logic [31:0] exp);
    addr_i = a; re_i = 1'b1;
    @(negedge clk_i);
    re_i = 1'b0;
    check(name, rdata_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones_left;
    int unsigned k;
    logic [7:0]  a;
    logic [31:0] d;

    rst_ni = 1'b0; addr_i = '0; wdata_i = '0; we_i = 0; re_i = 0; event_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // 1. reset state and INFO
    check("reset rdata_o", rdata_o, 32'h0);
    check("reset irq_o", {31'h0, irq_o}, 32'h0);
    bus_rd(8'h04, "INFO", 32'h0000_4004);
    for (int n = 0; n < NUM_CNTRS; n++) begin
      bus_rd(ch_addr(n, 4), "reset LO", 32'h0);
      bus_rd(ch_addr(n, 8), "reset HI", 32'h0);
    end

    // 2. cycle count for exactly 100 edges, then hold
    bus_wr(8'h00, 32'h1);
    bus_wr(ch_addr(0, 0), 32'h1);
    repeat (99) @(negedge clk_i);
    bus_wr(ch_addr(0, 0), 32'h2);
    bus_rd(ch_addr(0, 4), "ch0 LO after 100 cycles", 32'd100);
    bus_rd(ch_addr(0, 8), "ch0 HI after 100 cycles", 32'd0);
    bus_rd(ch_addr(0, 4), "ch0 LO held", 32'd100);

    // 3. event counting: exactly 37 events in 50 cycles; ch2 in CLEAR ignores events
    bus_wr(ch_addr(1, 0), 32'h3);
    ones_left = 37;
    for (int i = 0; i < 50; i++) begin
      event_i = 4'b0100;
      if ($urandom_range(50 - i - 1, 0) < ones_left) begin
        event_i[1] = 1'b1;
        ones_left--;
      end
      @(negedge clk_i);
    end
    event_i = '0;
    bus_rd(ch_addr(1, 4), "ch1 LO events", 32'd37);
    bus_rd(ch_addr(2, 4), "ch2 LO in CLEAR", 32'd0);

    // 4. wrap from all-ones, sticky ovf, irq one cycle later, W1C
    bus_wr(ch_addr(0, 8), 32'hFFFF_FFFF);
    bus_wr(ch_addr(0, 4), 32'hFFFF_FFFE);
    bus_wr(ch_addr(0, 0), 32'h5);
    repeat (2) @(negedge clk_i);
    bus_rd(ch_addr(0, 12), "ch0 STATUS after wrap", 32'h1);
    check("irq_o after wrap", {31'h0, irq_o}, 32'h1);
    bus_wr(ch_addr(0, 12), 32'h1);
    @(negedge clk_i);
    check("irq_o after W1C", {31'h0, irq_o}, 32'h0);
    bus_rd(ch_addr(0, 12), "ch0 STATUS after W1C", 32'h0);

    // 5. LO read while crossing 0xFFFF_FFFF: shadow holds the old hi word
    bus_wr(ch_addr(0, 0), 32'h2);
    bus_wr(ch_addr(0, 8), 32'h0);
    bus_wr(ch_addr(0, 4), 32'hFFFF_FFFF);
    bus_wr(ch_addr(0, 0), 32'h5);
    bus_rd(ch_addr(0, 4), "ch0 LO at carry", 32'hFFFF_FFFF);
    bus_rd(ch_addr(0, 8), "ch0 HI shadow at carry", 32'h0);

    // 6. clear_all while counting, then asynchronous reset mid-cycle
    bus_wr(ch_addr(1, 0), 32'h1);
    repeat (10) @(negedge clk_i);
    bus_wr(8'h00, 32'h3);
    bus_rd(ch_addr(0, 4), "ch0 LO after clear_all", 32'h0);
    bus_rd(ch_addr(0, 12), "ch0 STATUS after clear_all", 32'h0);
    bus_rd(ch_addr(1, 4), "ch1 LO two cycles after clear_all", 32'd2);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rdata_o async reset", rdata_o, 32'h0);
    check("irq_o async reset", {31'h0, irq_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bus_rd(8'h00, "GCTRL after reset", 32'h0);
    bus_wr(ch_addr(1, 0), 32'h1);
    repeat (5) @(negedge clk_i);
    bus_rd(ch_addr(1, 4), "ch1 LO without global_en", 32'h0);

    // Randomized traffic, checked every cycle by the model comparison
    bus_wr(8'h00, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(99);
      a = {4'($urandom_range(6)), 4'($urandom_range(15))};
      d = $urandom;
      if ($urandom_range(1) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      if (a[7:2] == 6'd0) d = {30'h0, ($urandom_range(15) == 0), ($urandom_range(7) != 0)};
      addr_i  = a;
      wdata_i = d;
      we_i    = (k < 30);
      re_i    = (k < 5) || (k >= 30 && k < 60);
      event_i = 4'($urandom);
      @(negedge clk_i);
    end
    we_i = 0; re_i = 0; event_i = '0;
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
